// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 types plus the word packer's state encoding and word-placement helper.
package sm4_encryptor_pkg;

  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [31:0]  sm4_word_t;
  typedef logic [127:0] sm4_block_t;

  typedef enum logic [1:0] {
    eKey   = 2'd0,
    eData  = 2'd1,
    eIssue = 2'd2
  } packer_state_e;

  // Low bit of the 32-bit slice that word number idx occupies in a 128-bit block.
  // With msw_first set, word 0 lands in [127:96]; otherwise it lands in [31:0].
  function automatic logic [6:0] word_lo(input logic [1:0] idx, input logic msw_first);
    return msw_first ? {~idx, 5'b00000} : {idx, 5'b00000};
  endfunction

endpackage

// File: rtl/sm4_word_packer.sv
// Packs a 32-bit word stream into one SM4 request (4 key words + 4 content words)
// and holds it on v_o until the core takes it. A first_i word outside the start of
// a request restarts collection; stray words at the start are dropped. Both count
// as framing errors in a saturating counter.
// Optional feature: define SM4_PACKER_KEY_REUSE_EN to allow content-only requests
// that reuse the last completed key.
module sm4_word_packer
  import sm4_encryptor_pkg::*;
#(
  parameter int MSW_FIRST_P = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [31:0]  word_i,
  input  logic         word_v_i,
  output logic         word_ready_o,
  input  logic         first_i,
  input  logic         mode_i,
  input  logic         reuse_key_i,
  output logic [127:0] content_o,
  output logic [127:0] key_o,
  output logic         encode_or_decode_o,
  output logic         v_o,
  input  logic         ready_i,
  output logic [7:0]   err_cnt_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);
  localparam logic       MSW_FIRST = (MSW_FIRST_P != 0);

  packer_state_e state_r, state_n;
  logic [1:0]    idx_r, idx_n, wr_idx;
  sm4_block_t    key_stage_r, key_r, content_r, key_full;
  logic          mode_r;
  logic [7:0]    err_cnt_r;
  logic          accept, at_start, key_wr, content_wr, commit_key, mode_wr;
  logic [1:0]    err_inc;
  logic [6:0]    wr_lo;
  logic [8:0]    err_sum;
  logic          reuse_hit, reuse_bad;

  assign word_ready_o       = (state_r != eIssue);
  assign v_o                = (state_r == eIssue);
  assign content_o          = content_r;
  assign key_o              = key_r;
  assign encode_or_decode_o = mode_r;
  assign err_cnt_o          = err_cnt_r;

  assign accept   = word_v_i & word_ready_o;
  assign at_start = (state_r == eKey) && (idx_r == 2'd0);

`ifdef SM4_PACKER_KEY_REUSE_EN
  logic key_valid_r;

  assign reuse_hit = reuse_key_i & key_valid_r;
  assign reuse_bad = reuse_key_i & ~key_valid_r;

  // Remember whether a complete key has been loaded since reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)       key_valid_r <= 1'b0;
    else if (commit_key) key_valid_r <= 1'b1;
  end
`else
  logic unused_reuse_key;

  assign unused_reuse_key = reuse_key_i;
  assign reuse_hit        = 1'b0;
  assign reuse_bad        = 1'b0;
`endif

  // Next-state, word-write strobes and error increment for the accepted word.
  always_comb begin
    state_n    = state_r;
    idx_n      = idx_r;
    wr_idx     = idx_r;
    key_wr     = 1'b0;
    content_wr = 1'b0;
    commit_key = 1'b0;
    mode_wr    = 1'b0;
    err_inc    = 2'd0;
    case (state_r)
      eIssue: begin
        if (ready_i) begin
          state_n = eKey;
          idx_n   = 2'd0;
        end
      end
      default: begin
        if (accept) begin
          if (first_i) begin
            mode_wr = 1'b1;
            wr_idx  = 2'd0;
            idx_n   = 2'd1;
            err_inc = {1'b0, ~at_start} + {1'b0, reuse_bad};
            if (reuse_hit) begin
              content_wr = 1'b1;
              state_n    = eData;
            end else begin
              key_wr  = 1'b1;
              state_n = eKey;
            end
          end else if (at_start) begin
            err_inc = 2'd1;
          end else if (state_r == eKey) begin
            key_wr = 1'b1;
            if (idx_r == LAST_IDX) begin
              commit_key = 1'b1;
              state_n    = eData;
              idx_n      = 2'd0;
            end else begin
              idx_n = idx_r + 2'd1;
            end
          end else begin
            content_wr = 1'b1;
            if (idx_r == LAST_IDX) begin
              state_n = eIssue;
              idx_n   = 2'd0;
            end else begin
              idx_n = idx_r + 2'd1;
            end
          end
        end
      end
    endcase
  end

  // Place the incoming word into the key being assembled and form the saturating error sum.
  always_comb begin
    wr_lo    = word_lo(wr_idx, MSW_FIRST);
    key_full = key_stage_r;
    key_full[wr_lo +: 32] = word_i;
    err_sum  = {1'b0, err_cnt_r} + {7'd0, err_inc};
  end

  // State register and word counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= eKey;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
    end
  end

  // Key staging, committed key, content, mode and error count registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      key_stage_r <= '0;
      key_r       <= '0;
      content_r   <= '0;
      mode_r      <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      if (key_wr)     key_stage_r <= key_full;
      if (commit_key) key_r <= key_full;
      if (content_wr) content_r[wr_lo +: 32] <= word_i;
      if (mode_wr)    mode_r <= mode_i;
      err_cnt_r <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_sm4_word_packer.sv
// Self-checking bench for sm4_word_packer: directed scenarios followed by random
// traffic, all checked against a request-level model built from word queues.
module tb_sm4_word_packer;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic [31:0]  word_i;
  logic         word_v_i;
  logic         word_ready_o;
  logic         first_i;
  logic         mode_i;
  logic         reuse_key_i;
  logic [127:0] content_o;
  logic [127:0] key_o;
  logic         encode_or_decode_o;
  logic         v_o;
  logic         ready_i;
  logic [7:0]   err_cnt_o;

`ifdef SM4_PACKER_KEY_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  sm4_word_packer #(.MSW_FIRST_P(1)) dut (
    .clk_i              (clk_i),
    .reset_ni           (reset_ni),
    .word_i             (word_i),
    .word_v_i           (word_v_i),
    .word_ready_o       (word_ready_o),
    .first_i            (first_i),
    .mode_i             (mode_i),
    .reuse_key_i        (reuse_key_i),
    .content_o          (content_o),
    .key_o              (key_o),
    .encode_or_decode_o (encode_or_decode_o),
    .v_o                (v_o),
    .ready_i            (ready_i),
    .err_cnt_o          (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: words of the request in progress, plus what is being issued.
  logic [31:0]  mw[$];
  bit           m_reuse_req, m_key_valid, m_issuing, m_mode_cur, m_mode_out;
  logic [127:0] m_key_commit, m_key_out, m_content_out;
  int           m_err;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mw.delete();
    m_reuse_req   = 1'b0;
    m_key_valid   = 1'b0;
    m_issuing     = 1'b0;
    m_mode_cur    = 1'b0;
    m_mode_out    = 1'b0;
    m_key_commit  = '0;
    m_key_out     = '0;
    m_content_out = '0;
    m_err         = 0;
  endtask

  task automatic incErr();
    if (m_err < 255) m_err++;
  endtask

  // Apply the request-level rules to whatever the bench is driving at this edge.
  task automatic modelEdge();
    int need;
    if (m_issuing) begin
      if (ready_i) m_issuing = 1'b0;
    end else if (word_v_i) begin
      if (first_i) begin
        if (mw.size() != 0) incErr();
        mw.delete();
        mw.push_back(word_i);
        m_mode_cur  = mode_i;
        m_reuse_req = REUSE_EN && reuse_key_i && m_key_valid;
        if (REUSE_EN && reuse_key_i && !m_key_valid) incErr();
      end else if (mw.size() == 0) begin
        incErr();
      end else begin
        mw.push_back(word_i);
      end
      if (!m_reuse_req && mw.size() == 4) begin
        m_key_valid  = 1'b1;
        m_key_commit = {mw[0], mw[1], mw[2], mw[3]};
      end
      need = m_reuse_req ? 4 : 8;
      if (mw.size() == need) begin
        m_content_out = {mw[need-4], mw[need-3], mw[need-2], mw[need-1]};
        m_key_out     = m_key_commit;
        m_mode_out    = m_mode_cur;
        m_issuing     = 1'b1;
        m_reuse_req   = 1'b0;
        mw.delete();
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("word_ready", 128'(word_ready_o), 128'(!m_issuing));
    checkOutput("v", 128'(v_o), 128'(m_issuing));
    checkOutput("err_cnt", 128'(err_cnt_o), 128'(m_err));
    if (m_issuing) begin
      checkOutput("key", key_o, m_key_out);
      checkOutput("content", content_o, m_content_out);
      checkOutput("mode", 128'(encode_or_decode_o), 128'(m_mode_out));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance model and DUT.
  task automatic applyStimulus(input logic [31:0] w, input bit v, input bit f,
                               input bit m, input bit r, input bit rdy);
    word_i      = w;
    word_v_i    = v;
    first_i     = f;
    mode_i      = m;
    reuse_key_i = r;
    ready_i     = rdy;
    checkAll();
    @(posedge clk_i);
    modelEdge();
    @(negedge clk_i);
  endtask

  task automatic doReset();
    reset_ni = 1'b0;
    #1;
    checkOutput("rst_v", 128'(v_o), 128'(0));
    checkOutput("rst_key", key_o, 128'(0));
    checkOutput("rst_content", content_o, 128'(0));
    checkOutput("rst_mode", 128'(encode_or_decode_o), 128'(0));
    checkOutput("rst_err", 128'(err_cnt_o), 128'(0));
    modelReset();
    @(negedge clk_i);
    reset_ni = 1'b1;
    checkOutput("rst_ready", 128'(word_ready_o), 128'(1));
  endtask

  task automatic sendWords(input logic [31:0] ws[], input bit first_at0, input bit m, input bit r);
    foreach (ws[i]) applyStimulus(ws[i], 1'b1, first_at0 && (i == 0), m, r && (i == 0), 1'b0);
  endtask

  task automatic drain();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] pat[] = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
  logic [31:0] eight[];
  logic [127:0] old_key;

  initial begin
    word_i = '0; word_v_i = 0; first_i = 0; mode_i = 0; reuse_key_i = 0; ready_i = 0;
    reset_ni = 1'b1;
    @(negedge clk_i);
    doReset();

    // Scenario 1: known pattern as key and content, mode 1.
    eight = new[8];
    foreach (eight[i]) eight[i] = pat[i % 4];
    sendWords(eight, 1'b1, 1'b1, 1'b0);
    checkOutput("s1_v", 128'(v_o), 128'(1));
    checkOutput("s1_key", key_o, 128'h0123456789abcdeffedcba9876543210);
    checkOutput("s1_content", content_o, 128'h0123456789abcdeffedcba9876543210);
    checkOutput("s1_mode", 128'(encode_or_decode_o), 128'(1));

    // Scenario 2: core back-pressure while issuing; offered words must not be taken.
    repeat (5) applyStimulus($urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_ready_low", 128'(word_ready_o), 128'(0));
    drain();
    checkOutput("s2_v_fell", 128'(v_o), 128'(0));
    checkOutput("s2_ready_back", 128'(word_ready_o), 128'(1));

    // Scenario 3: restart on the third word.
    eight = new[10];
    foreach (eight[i]) eight[i] = $urandom;
    applyStimulus(eight[0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(eight[1], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(eight[2], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_err", 128'(err_cnt_o), 128'(1));
    for (int i = 3; i < 10; i++) applyStimulus(eight[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_v", 128'(v_o), 128'(1));
    checkOutput("s3_key", key_o, {eight[2], eight[3], eight[4], eight[5]});
    checkOutput("s3_content", content_o, {eight[6], eight[7], eight[8], eight[9]});
    drain();

`ifdef SM4_PACKER_KEY_REUSE_EN
    // Scenario 4: content-only request reuses the previous key.
    doReset();
    eight = new[8];
    foreach (eight[i]) eight[i] = $urandom;
    sendWords(eight, 1'b1, 1'b0, 1'b0);
    old_key = {eight[0], eight[1], eight[2], eight[3]};
    drain();
    foreach (pat[i]) applyStimulus(pat[i] ^ 32'h5a5a5a5a, 1'b1, i == 0, 1'b1, i == 0, 1'b0);
    checkOutput("s4_v", 128'(v_o), 128'(1));
    checkOutput("s4_old_key", key_o, old_key);
    checkOutput("s4_new_content", content_o, {pat[0], pat[1], pat[2], pat[3]} ^ {4{32'h5a5a5a5a}});
    drain();
    doReset();
    foreach (pat[i]) applyStimulus(pat[i], 1'b1, i == 0, 1'b0, i == 0, 1'b0);
    checkOutput("s4_err", 128'(err_cnt_o), 128'(1));
    checkOutput("s4_no_v", 128'(v_o), 128'(0));
    foreach (pat[i]) applyStimulus(pat[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_v8", 128'(v_o), 128'(1));
    drain();
`else
    old_key = '0;
`endif

    // Scenario 5: reset with two content words collected, then a clean request.
    eight = new[6];
    foreach (eight[i]) eight[i] = $urandom;
    sendWords(eight, 1'b1, 1'b1, 1'b0);
    #2;
    doReset();
    eight = new[8];
    foreach (eight[i]) eight[i] = $urandom;
    sendWords(eight, 1'b1, 1'b1, 1'b0);
    checkOutput("s5_v", 128'(v_o), 128'(1));
    checkOutput("s5_key", key_o, {eight[0], eight[1], eight[2], eight[3]});
    checkOutput("s5_content", content_o, {eight[4], eight[5], eight[6], eight[7]});
    drain();

    // Scenario 6: stray words saturate the error counter.
    doReset();
    repeat (300) applyStimulus($urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6_err_sat", 128'(err_cnt_o), 128'(255));
    checkOutput("s6_no_v", 128'(v_o), 128'(0));

    // Random traffic.
    doReset();
    repeat (3000)
      applyStimulus($urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                    1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
